// File: rtl/pkt_bus_arbiter_if.sv
// Bus bundle between the source FIFOs, the arbiter and the packet checker.
// The arbiter uses the slave modport; sources and the checker sit on the master side.
interface pkt_bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic                      error_in;
  logic [NUM_REQ-1:0]        grant;
  logic [DATA_W-1:0]         data_out;
  logic                      valid_out;
  logic [NUM_REQ-1:0]        abort;
  logic [1:0]                owner;
  logic                      busy;
  logic [7:0]                err_count;

  modport slave (
    input  req, req_data, req_last, error_in,
    output grant, data_out, valid_out, abort, owner, busy, err_count
  );

  modport master (
    output req, req_data, req_last, error_in,
    input  grant, data_out, valid_out, abort, owner, busy, err_count
  );
endinterface

// File: rtl/pkt_bus_arbiter.sv
// Round-robin arbiter sharing the packet-checker bus between four sources.
// A grant is held for a whole packet; each accepted word is registered onto
// data_out. The owner is aborted on checker error, over-length or stall timeout.
module pkt_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int MAX_PKT = 8,
  parameter int TIMEOUT = 15
) (
  input logic           clk,
  input logic           reset,
  pkt_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    ABORT = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam logic [3:0] MAX_CNT  = 4'(MAX_PKT);
  localparam logic [3:0] STALL_TO = 4'(TIMEOUT);

  state_t             state, state_nxt;
  logic [1:0]         owner, owner_nxt;
  logic [NUM_REQ-1:0] grant, grant_nxt;
  logic [NUM_REQ-1:0] abort, abort_nxt;
  logic [DATA_W-1:0]  data_q, data_nxt;
  logic               valid_q, valid_nxt;
  logic [3:0]         word_cnt, word_nxt;
  logic [3:0]         stall_cnt, stall_nxt;
  logic [7:0]         err_count, err_nxt;

  logic [1:0]         pick;
  logic [1:0]         cand;
  logic               found;
  logic               accept;
  logic               go_abort;
  logic               go_gap;

  // Registers every piece of arbiter state; reset leaves owner at 3 so source 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 2'd3;
      grant     <= '0;
      abort     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      word_cnt  <= '0;
      stall_cnt <= '0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      grant     <= grant_nxt;
      abort     <= abort_nxt;
      data_q    <= data_nxt;
      valid_q   <= valid_nxt;
      word_cnt  <= word_nxt;
      stall_cnt <= stall_nxt;
      err_count <= err_nxt;
    end
  end

  // Next-state logic: round-robin pick in IDLE, word/stall accounting and exit priority in XFER.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    grant_nxt = grant;
    abort_nxt = '0;
    data_nxt  = data_q;
    valid_nxt = 1'b0;
    word_nxt  = word_cnt;
    stall_nxt = stall_cnt;
    err_nxt   = err_count;
    pick      = owner;
    cand      = owner;
    found     = 1'b0;
    accept    = 1'b0;
    go_abort  = 1'b0;
    go_gap    = 1'b0;

    for (int k = 1; k <= 4; k++) begin
      cand = owner + 2'(k);
      if (!found && bus.req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (found) begin
          state_nxt       = XFER;
          owner_nxt       = pick;
          grant_nxt       = '0;
          grant_nxt[pick] = 1'b1;
          word_nxt        = '0;
          stall_nxt       = '0;
        end
      end

      XFER: begin
        accept = bus.req[owner];
        if (accept) begin
          word_nxt  = word_cnt + 4'd1;
          stall_nxt = '0;
          data_nxt  = bus.req_data[int'(owner)*DATA_W +: DATA_W];
          valid_nxt = 1'b1;
        end else begin
          stall_nxt = stall_cnt + 4'd1;
        end

        if (bus.error_in)
          go_abort = 1'b1;
        else if (accept && bus.req_last[owner])
          go_gap = 1'b1;
        else if (accept && (word_cnt + 4'd1 == MAX_CNT))
          go_abort = 1'b1;
        else if (!accept && (stall_cnt + 4'd1 == STALL_TO))
          go_abort = 1'b1;

        if (go_abort) begin
          state_nxt        = ABORT;
          grant_nxt        = '0;
          abort_nxt[owner] = 1'b1;
          if (err_count != 8'hFF)
            err_nxt = err_count + 8'd1;
        end else if (go_gap) begin
          state_nxt = GAP;
          grant_nxt = '0;
        end
      end

      ABORT: begin
        grant_nxt = '0;
        state_nxt = GAP;
      end

      GAP: begin
        grant_nxt = '0;
        word_nxt  = '0;
        stall_nxt = '0;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  assign bus.grant     = grant;
  assign bus.abort     = abort;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.owner     = owner;
  assign bus.busy      = (state != IDLE);
  assign bus.err_count = err_count;

endmodule

// File: tb/tb_pkt_bus_arbiter.sv
// Directed bench for pkt_bus_arbiter: single packet, fairness, checker error,
// over-length, stall timeout and asynchronous reset mid-packet.
module tb_pkt_bus_arbiter;

  logic clk;
  logic reset;
  int   check_count;
  int   pass_count;

  pkt_bus_arbiter_if #(.NUM_REQ(4), .DATA_W(16)) bus ();

  pkt_bus_arbiter #(
    .NUM_REQ(4),
    .DATA_W (16),
    .MAX_PKT(8),
    .TIMEOUT(15)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value and reports a mismatch.
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs === exp)
      pass_count++;
    else
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advances to just after the next rising edge, where registered outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one source's word and last flag without disturbing the others.
  task automatic apply_stimulus(input int src, input logic [15:0] word, input logic last);
    bus.req_data[src*16 +: 16] = word;
    bus.req_last[src]          = last;
  endtask

  // Pulses reset for one edge and releases it away from the clock edge.
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Main directed sequence.
  initial begin
    check_count  = 0;
    pass_count   = 0;
    reset        = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.error_in = 1'b0;
    step();
    step();
    reset = 1'b0;

    check_output("rst_grant", 32'(bus.grant), 32'h0);
    check_output("rst_owner", 32'(bus.owner), 32'h3);
    check_output("rst_busy", 32'(bus.busy), 32'h0);
    check_output("rst_valid", 32'(bus.valid_out), 32'h0);
    check_output("rst_data", 32'(bus.data_out), 32'h0);
    check_output("rst_abort", 32'(bus.abort), 32'h0);
    check_output("rst_err", 32'(bus.err_count), 32'h0);

    // T1: single two-word packet from source 0.
    bus.req = 4'b0001;
    apply_stimulus(0, 16'hFBA0, 1'b0);
    step();
    check_output("t1_grant", 32'(bus.grant), 32'h1);
    check_output("t1_owner", 32'(bus.owner), 32'h0);
    check_output("t1_valid0", 32'(bus.valid_out), 32'h0);
    step();
    check_output("t1_data0", 32'(bus.data_out), 32'hFBA0);
    check_output("t1_valid1", 32'(bus.valid_out), 32'h1);
    apply_stimulus(0, 16'hF0A1, 1'b1);
    step();
    check_output("t1_data1", 32'(bus.data_out), 32'hF0A1);
    check_output("t1_valid2", 32'(bus.valid_out), 32'h1);
    check_output("t1_gap_grant", 32'(bus.grant), 32'h0);
    check_output("t1_gap_busy", 32'(bus.busy), 32'h1);
    check_output("t1_abort_a", 32'(bus.abort), 32'h0);
    bus.req = 4'b0000;
    bus.req_last = '0;
    step();
    check_output("t1_idle_busy", 32'(bus.busy), 32'h0);
    check_output("t1_idle_valid", 32'(bus.valid_out), 32'h0);
    check_output("t1_abort_b", 32'(bus.abort), 32'h0);

    // T2: all sources requesting, two-word packets, rotating grant from a fresh reset.
    do_reset();
    bus.req = 4'b1111;
    for (int s = 0; s < 4; s++) apply_stimulus(s, 16'hC0D0 + 16'(s), 1'b0);
    for (int p = 0; p < 5; p++) begin
      step();
      check_output($sformatf("t2_grant%0d", p), 32'(bus.grant), 32'(4'b0001 << (p % 4)));
      check_output($sformatf("t2_owner%0d", p), 32'(bus.owner), 32'(p % 4));
      step();
      check_output($sformatf("t2_data%0d", p), 32'(bus.data_out), 32'h0000C0D0 + 32'(p % 4));
      bus.req_last = 4'b1111;
      step();
      check_output($sformatf("t2_gap%0d", p), 32'(bus.grant), 32'h0);
      bus.req_last = 4'b0000;
      step();
    end
    bus.req = 4'b0000;
    step();

    // T3: checker error on source 2's second word.
    bus.req = 4'b0100;
    apply_stimulus(2, 16'hF102, 1'b0);
    step();
    check_output("t3_grant", 32'(bus.grant), 32'h4);
    step();
    check_output("t3_data0", 32'(bus.data_out), 32'hF102);
    apply_stimulus(2, 16'hA5D3, 1'b0);
    bus.error_in = 1'b1;
    step();
    check_output("t3_abort", 32'(bus.abort), 32'h4);
    check_output("t3_grant0", 32'(bus.grant), 32'h0);
    check_output("t3_err", 32'(bus.err_count), 32'h1);
    check_output("t3_data1", 32'(bus.data_out), 32'hA5D3);
    bus.error_in = 1'b0;
    bus.req = 4'b0000;
    step();
    check_output("t3_abort_pulse", 32'(bus.abort), 32'h0);
    step();

    // T4: source 1 sends eight words without last.
    bus.req = 4'b0010;
    apply_stimulus(1, 16'hF1F0, 1'b0);
    step();
    check_output("t4_grant", 32'(bus.grant), 32'h2);
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(1, 16'hF1F0 + 16'(k), 1'b0);
      step();
      if (k < 7)
        check_output($sformatf("t4_noabort%0d", k), 32'(bus.abort), 32'h0);
    end
    check_output("t4_abort", 32'(bus.abort), 32'h2);
    check_output("t4_data", 32'(bus.data_out), 32'hF1F7);
    check_output("t4_err", 32'(bus.err_count), 32'h2);
    check_output("t4_grant0", 32'(bus.grant), 32'h0);
    bus.req = 4'b0000;
    step();
    step();

    // T5: source 3 sends one word then stalls until the timeout fires.
    bus.req = 4'b1000;
    apply_stimulus(3, 16'hFDC9, 1'b0);
    step();
    check_output("t5_grant", 32'(bus.grant), 32'h8);
    check_output("t5_owner", 32'(bus.owner), 32'h3);
    step();
    check_output("t5_data", 32'(bus.data_out), 32'hFDC9);
    bus.req = 4'b0000;
    for (int c = 0; c < 14; c++) step();
    check_output("t5_pre_abort", 32'(bus.abort), 32'h0);
    check_output("t5_pre_grant", 32'(bus.grant), 32'h8);
    step();
    check_output("t5_abort", 32'(bus.abort), 32'h8);
    check_output("t5_err", 32'(bus.err_count), 32'h3);
    step();
    step();

    // T6: asynchronous reset in the middle of a transfer.
    bus.req = 4'b0001;
    apply_stimulus(0, 16'h1234, 1'b0);
    step();
    check_output("t6_grant", 32'(bus.grant), 32'h1);
    step();
    check_output("t6_valid", 32'(bus.valid_out), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_output("t6_rst_grant", 32'(bus.grant), 32'h0);
    check_output("t6_rst_valid", 32'(bus.valid_out), 32'h0);
    check_output("t6_rst_abort", 32'(bus.abort), 32'h0);
    check_output("t6_rst_owner", 32'(bus.owner), 32'h3);
    check_output("t6_rst_err", 32'(bus.err_count), 32'h0);
    #1;
    reset = 1'b0;
    bus.req = 4'b0110;
    step();
    check_output("t6_regrant", 32'(bus.grant), 32'h2);
    check_output("t6_reowner", 32'(bus.owner), 32'h1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
